// File: rtl/program_loader_if.sv
// Byte-stream handshake and instruction-memory write port seen by program_loader.
// master = the loader (consumes bytes, drives writes); slave = the surrounding system.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [15:0]       im_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Instruction-memory loader: length-prefixed byte frames -> 16-bit words written from address 0.
// Optional trailing XOR checksum enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  program_loader_if.master    bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     word_count
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, CSUM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, DONE} state_t;
`endif

  localparam int unsigned      MAX_WORDS   = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0]  MAX_WORDS_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  ONE_WORD    = (ADDR_W+1)'(1);

  state_t state, state_nxt;

  logic              ready_c, busy_c, hold_c, done_c, load_start;
  logic              len_acc, hi_acc, lo_acc;
  logic [ADDR_W:0]   rem;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi_p0;
  logic              wr_vld_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [15:0]       wr_data_p1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic              err_c;
  logic [7:0]        csum_p0;
`endif

  // Length byte -> word count; 0 means a full memory, oversize lengths clamp to memory size.
  function automatic logic [ADDR_W:0] len_to_words(input logic [7:0] len);
    if (len == 8'd0 || 32'(len) > MAX_WORDS) return MAX_WORDS_W;
    return (ADDR_W+1)'(len);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready_c    = 1'b0;
    busy_c     = 1'b0;
    hold_c     = 1'b0;
    done_c     = 1'b0;
    load_start = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    err_c      = 1'b0;
`endif
    case (state)
      IDLE: if (start) begin state_nxt = LEN; load_start = 1'b1; end
      LEN: begin
        ready_c = 1'b1; busy_c = 1'b1; hold_c = 1'b1;
        if (bus.in_valid) state_nxt = HI;
      end
      HI: begin
        ready_c = 1'b1; busy_c = 1'b1; hold_c = 1'b1;
        if (bus.in_valid) state_nxt = LO;
      end
      LO: begin
        ready_c = 1'b1; busy_c = 1'b1; hold_c = 1'b1;
        if (bus.in_valid) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_nxt = (rem == ONE_WORD) ? CSUM : HI;
`else
          state_nxt = (rem == ONE_WORD) ? DONE : HI;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CSUM: begin
        ready_c = 1'b1; busy_c = 1'b1; hold_c = 1'b1;
        if (bus.in_valid) state_nxt = (bus.in_data == csum_p0) ? DONE : ERR;
      end
      ERR: begin
        err_c = 1'b1; hold_c = 1'b1;
        if (start) begin state_nxt = LEN; load_start = 1'b1; end
      end
`endif
      DONE: begin
        done_c = 1'b1;
        if (start) begin state_nxt = LEN; load_start = 1'b1; end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign len_acc = (state == LEN) & bus.in_valid;
  assign hi_acc  = (state == HI)  & bus.in_valid;
  assign lo_acc  = (state == LO)  & bus.in_valid;

  // Control counters and the registered write port (p1 = cycle after the low-byte accept).
  always_ff @(posedge clk) begin
    if (rst) begin
      rem        <= '0;
      addr       <= '0;
      word_count <= '0;
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= 1'b0;
      if (load_start) begin
        addr       <= '0;
        word_count <= '0;
      end
      if (len_acc) rem <= len_to_words(bus.in_data);
      if (lo_acc) begin
        wr_vld_p1  <= 1'b1;
        wr_addr_p1 <= addr;
        wr_data_p1 <= {hi_p0, bus.in_data};
        addr       <= addr + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
        rem        <= rem - ONE_WORD;
      end
    end
  end

  // Byte-capture stage: high byte and running XOR.
  always_ff @(posedge clk) begin
    if (hi_acc) hi_p0 <= bus.in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (load_start)           csum_p0 <= 8'd0;
    else if (hi_acc | lo_acc) csum_p0 <= csum_p0 ^ bus.in_data;
`endif
  end

  assign bus.in_ready = ready_c;
  assign bus.im_we    = wr_vld_p1;
  assign bus.im_addr  = wr_addr_p1;
  assign bus.im_wdata = wr_data_p1;
  assign busy         = busy_c;
  assign cpu_hold     = hold_c;
  assign done         = done_c;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign error        = err_c;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame-level reference model plus literal spot checks.
module tb_program_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            cpu_hold, busy, done, error;
  logic [ADDR_W:0] word_count;

  program_loader_if #(.ADDR_W(ADDR_W)) bus();

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.master),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: position within the frame decides what each accepted byte means.
  bit                m_loading, m_done, m_err, m_we;
  int                m_pos, m_n, m_wc, m_ctr;
  logic [7:0]        m_xor, m_hi;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]       m_wdata;

  always @(posedge clk) begin
    if (rst) begin
      m_loading = 0; m_done = 0; m_err = 0; m_we = 0; m_wc = 0;
      m_addr = '0; m_wdata = '0;
    end else begin
      m_we = 0;
      if (!m_loading) begin
        if (start) begin
          m_loading = 1; m_done = 0; m_err = 0; m_wc = 0;
          m_pos = 0; m_ctr = 0; m_xor = 8'd0;
        end
      end else if (bus.in_valid) begin
        if (m_pos == 0) begin
          m_n = (bus.in_data == 8'd0) ? DEPTH :
                ((int'(bus.in_data) > DEPTH) ? DEPTH : int'(bus.in_data));
        end else if (m_pos <= 2 * m_n) begin
          m_xor ^= bus.in_data;
          if (m_pos % 2 == 1) m_hi = bus.in_data;
          else begin
            m_we = 1; m_addr = m_ctr[ADDR_W-1:0]; m_wdata = {m_hi, bus.in_data};
            m_ctr = (m_ctr + 1) % DEPTH; m_wc++;
          end
          if (m_pos == 2 * m_n && !CS_EN) begin m_loading = 0; m_done = 1; end
        end else begin
          if (bus.in_data == m_xor) m_done = 1; else m_err = 1;
          m_loading = 0;
        end
        m_pos++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   bus.in_ready, m_loading);
      chk("busy",       busy,         m_loading);
      chk("cpu_hold",   cpu_hold,     m_loading | m_err);
      chk("done",       done,         m_done);
      chk("error",      error,        m_err);
      chk("word_count", word_count,   m_wc);
      chk("im_we",      bus.im_we,    m_we);
      chk("im_addr",    bus.im_addr,  m_addr);
      chk("im_wdata",   bus.im_wdata, m_wdata);
    end
  end

  logic [ADDR_W+15:0] wlog[$];
  int npulse = 0;
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      wlog.push_back({bus.im_addr, bus.im_wdata});
      npulse++;
    end
  end

  logic [7:0] frame[$];

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    bit rdy;
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      if (noise) start = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    forever begin
      @(negedge clk); rdy = bus.in_ready;
      @(posedge clk); #1;
      n++;
      if (rdy === 1'b1) break;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got no in_ready, expected byte %0h accepted", b);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input int max_gap, input bit noise);
    wlog.delete();
    npulse = 0;
    do_start();
    foreach (frame[i]) send_byte(frame[i], $urandom_range(0, max_gap), noise);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic build_frame(input logic [7:0] len, input int nwords, input bit bad_cs);
    logic [7:0] x, b;
    x = 8'd0;
    frame.delete();
    frame.push_back(len);
    for (int i = 0; i < 2 * nwords; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      x ^= b;
    end
    if (CS_EN) frame.push_back(bad_cs ? (x ^ 8'h01) : x);
  endtask

  task automatic build_frame_a(input logic [7:0] cs);
    frame.delete();
    frame.push_back(8'h02); frame.push_back(8'h12); frame.push_back(8'h34);
    frame.push_back(8'hAB); frame.push_back(8'hCD);
    if (CS_EN) frame.push_back(cs);
  endtask

  task automatic check_frame_a(input string tag);
    chk({tag, "_pulses"}, npulse, 2);
    chk({tag, "_w0"}, (wlog.size() > 0) ? wlog[0] : '1, {8'h00, 16'h1234});
    chk({tag, "_w1"}, (wlog.size() > 1) ? wlog[1] : '1, {8'h01, 16'hABCD});
    chk({tag, "_done"}, done, 1);
    chk({tag, "_wc"}, word_count, 2);
    chk({tag, "_hold"}, cpu_hold, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected bench to end");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int nbad;
    logic [7:0] len;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_we", bus.im_we, 0);
    chk("rst_wdata", bus.im_wdata, 0);
    chk("rst_busy", busy, 0);

    // Idle with in_valid held high: nothing may be accepted.
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    repeat (10) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("idle_pulses", npulse, 0);
    chk("idle_ready", bus.in_ready, 0);

    build_frame_a(8'h40);
    run_frame(0, 0);
    check_frame_a("a");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    build_frame_a(8'h41);
    run_frame(0, 0);
    chk("bad_error", error, 1);
    chk("bad_done", done, 0);
    chk("bad_hold", cpu_hold, 1);
    build_frame_a(8'h40);
    run_frame(0, 0);
    chk("recover_done", done, 1);
    chk("recover_error", error, 0);
`endif

    build_frame_a(8'h40);
    run_frame(5, 1);
    check_frame_a("gaps");

    build_frame(8'h00, DEPTH, 1'b0);
    run_frame(0, 0);
    chk("full_wc", word_count, 256);
    chk("full_pulses", npulse, 256);
    chk("full_last_addr", (wlog.size() == 256) ? wlog[255][ADDR_W+15:16] : 'x, 8'hFF);
    nbad = 0;
    foreach (wlog[i]) if (wlog[i][ADDR_W+15:16] !== ADDR_W'(i)) nbad++;
    chk("full_addr_seq", nbad, 0);

    // Reset in the middle of a load, right after the high byte of word 1.
    wlog.delete();
    do_start();
    send_byte(8'h02, 0, 0); send_byte(8'h12, 0, 0);
    send_byte(8'h34, 0, 0); send_byte(8'hAB, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    npulse = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_wc", word_count, 0);
    bus.in_valid = 1'b1; bus.in_data = 8'hCD;
    repeat (10) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("mid_rst_pulses", npulse, 0);

    for (int k = 0; k < 6; k++) begin
      len = 8'($urandom_range(1, 6));
      bad = CS_EN && ($urandom_range(0, 1) == 1);
      build_frame(len, int'(len), bad);
      run_frame(3, 1);
      chk("rand_wc", word_count, len);
      chk("rand_pulses", npulse, len);
      chk("rand_done", done, !bad);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the CPU's instruction memory: receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words (high byte first) and writes them into instruction memory from address 0 upward. While a load is in progress it holds the CPU via `cpu_hold`. It reports completion, word count, and an optional checksum error. It sits between the host-facing byte source and the write port of instruction memory.

## Interface
- `ADDR_W`, default 8: instruction memory address width; maximum program length is 2^ADDR_W words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a load. Ignored while `busy`.
- `in_valid`  in  1  byte source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle. A byte transfers when `in_valid & in_ready` are both high at the rising edge.
- `im_we`  out  1  instruction memory write strobe, one cycle per word.
- `im_addr`  out  ADDR_W  write address.
- `im_wdata`  out  16  write data: `{hi_byte, lo_byte}`.
- `cpu_hold`  out  1  stalls the CPU (PC frozen, no register or memory writes).
- `busy`  out  1  a load is in progress.
- `done`  out  1  last load completed successfully. Sticky until the next `start`.
- `error`  out  1  checksum mismatch. Sticky until the next `start`.
- `word_count`  out  ADDR_W+1  number of words written by the current or last load.

## Operation
- Frame format: length byte L, then 2·N data bytes (high byte first, then low byte), then an optional checksum byte.
  - N = L, except L = 0 means N = 2^ADDR_W.
  - For ADDR_W < 8, an L greater than 2^ADDR_W is clamped to 2^ADDR_W.
- State machine states: IDLE, LEN, HI, LO, CSUM, DONE, ERR.
- IDLE:
  - Outputs: `in_ready`=0, `busy`=0.
  - On `start`: go to LEN. Clear `done`, `error`, `word_count`, address counter and running XOR. Set `cpu_hold`=1.
- LEN:
  - `in_ready`=1.
  - On accept: latch the remaining-word counter as N, then go to HI.
- HI:
  - `in_ready`=1.
  - On accept: latch the byte into the high register, XOR it into the checksum, then go to LO.
- LO:
  - `in_ready`=1.
  - On accept: XOR the byte into the checksum and register a write.
  - Write timing: next cycle `im_we`=1, `im_addr`=current address, `im_wdata`={hi, byte}.
  - After the write, increment the address (wraps modulo 2^ADDR_W), increment `word_count`, and decrement the remaining counter.
  - Next state: if the remaining count reaches 0, go to CSUM (macro on) or DONE (macro off); otherwise go to HI.
- CSUM:
  - `in_ready`=1.
  - On accept: if the byte equals the running XOR, go to DONE; otherwise go to ERR.
- DONE:
  - Outputs: `done`=1, `cpu_hold`=0, `busy`=0, `in_ready`=0.
  - On `start`: go to LEN, same clearing as from IDLE.
- ERR:
  - Outputs: `error`=1, `cpu_hold`=1 (a corrupt program must not run), `busy`=0, `in_ready`=0.
  - On `start`: go to LEN.
- `busy`=1 in LEN, HI, LO and CSUM. `start` is ignored in these states.
- `in_valid` low in any receiving state: hold the state with no side effects. Gaps between bytes of any length are legal.
- `rst` mid-load: abandon the load immediately and return to IDLE. Words already written stay in memory.

## Timing
- Reset values: state IDLE, `in_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=0, `busy`=0, `done`=0, `error`=0, `word_count`=0.
- `in_ready` and `busy` are decoded from the state register only. They never depend combinationally on `in_valid`.
- `im_we` is registered and is high exactly one cycle, one cycle after the accepting edge of each low byte.
- `cpu_hold` rises on the edge that leaves IDLE/DONE/ERR. It falls on the edge that enters DONE, which is the same edge as the final `im_we` pulse (macro off) or after the checksum (macro on).
- Throughput: one byte per cycle under continuous `in_valid`. An N-word load with macro on takes 2N+2 accepting cycles after `start`.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - CSUM state present; the frame ends with the XOR of all 2N data bytes.
  - A mismatch leads to ERR.
- Not defined:
  - CSUM and ERR states are removed; `error` is tied to 0.
  - The frame ends after the last low byte, and the loader goes from LO to DONE directly.

## Test plan
- Reset, then idle 10 cycles → all outputs 0. `in_valid`=1 is never accepted while `in_ready`=0.
- `start`, then bytes 02, 12, 34, AB, CD, checksum 40, streamed back-to-back → writes [0]=1234 and [1]=ABCD on consecutive `im_we` pulses; `done`=1; `word_count`=2; `cpu_hold` falls at DONE.
- Same frame with checksum 41 → `error`=1, `done`=0, `cpu_hold` stays 1. A following `start` plus a valid frame → `done`=1, `error`=0.
- Same frame with random `in_valid` gaps of 0–5 cycles → identical writes and data, and exactly 2 `im_we` pulses.
- L=00 with 512 data bytes (ADDR_W=8) → 256 writes to addresses 00–FF, `word_count`=256, address wraps to 0.
- `rst` asserted after the HI byte of word 1 → IDLE on the next edge, all outputs at reset values, and no further `im_we`.
